mem_bus_arbiter: RTL and testbench

- Shares the single external memory bus between the instruction-cache controller (fetch side, F) and the data writeback cache controller (memory side, M).
- Grants the bus per burst of blocksize beats and multiplexes address, write data and direction onto the bus.
- Routes the bus ready strobe back only to the granted side, so each controller's beat counter advances correctly.
- Keeps a data-cache writeback followed by its refill atomic, while preventing either side from starving the other.

---
 rtl/mem_bus_arbiter_pkg.sv | 15 +
 rtl/burst_beat_counter.sv | 48 ++++
 rtl/mux2.sv | 16 +
 rtl/mem_bus_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter slice.
//   owner_state_e : arbiter tenure state (no owner, fetch side owns, data side owns)
//   SIDE_F/SIDE_M : one-bit side encoding used for LastOwner and the mux selects
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_F = 2'd1,
    OWN_M = 2'd2
  } owner_state_e;

  localparam logic SIDE_F = 1'b0;
  localparam logic SIDE_M = 1'b1;

endpackage

// File: rtl/burst_beat_counter.sv
// Beat and burst counters for one bus tenure.
//   clk, reset : clock, asynchronous active-low reset
//   HReady     : a beat of the current owner completed this cycle
//   clear      : tenure ends (abort or handover); zeroes both counters
//   LastBeat   : this cycle's beat is the final beat of a burst
//   BurstLimit : the burst now ending reaches the tenure burst budget
module burst_beat_counter #(
  parameter int blocksize = 4,
  parameter int MaxBursts = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic HReady,
  input  logic clear,
  output logic LastBeat,
  output logic BurstLimit
);

  localparam int BeatBits  = $clog2(blocksize);
  localparam int BurstBits = $clog2(MaxBursts + 1);
  localparam logic [BeatBits-1:0]  FinalBeat = BeatBits'(blocksize - 1);
  localparam logic [BurstBits-1:0] BurstMax  = BurstBits'(MaxBursts);
  localparam logic [BurstBits-1:0] BurstLast = BurstBits'(MaxBursts - 1);

  logic [BeatBits-1:0]  BeatCnt;
  logic [BurstBits-1:0] BurstCnt;

  assign LastBeat   = HReady && (BeatCnt == FinalBeat);
  // BurstCnt saturates, so ">=" keeps a long-running owner yieldable once
  // the other side finally asks.
  assign BurstLimit = (BurstCnt >= BurstLast);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      BeatCnt  <= '0;
      BurstCnt <= '0;
    end else if (clear) begin
      BeatCnt  <= '0;
      BurstCnt <= '0;
    end else if (HReady) begin
      // blocksize is a power of two, so the final beat wraps to 0 naturally.
      BeatCnt <= BeatCnt + BeatBits'(1);
      if (LastBeat && (BurstCnt != BurstMax))
        BurstCnt <= BurstCnt + BurstBits'(1);
    end
  end

endmodule

// File: rtl/mux2.sv
// Generic two-input multiplexer.
//   d0, d1 : data inputs
//   s      : select (0 -> d0, 1 -> d1)
//   y      : selected data
module mux2 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? d1 : d0;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the external memory bus between the fetch side (F) and the data
// writeback side (M), one burst of blocksize beats at a time.
//   clk, reset              : clock, asynchronous active-low reset
//   HRequestF, HAddrF       : fetch side request and beat address
//   HRequestM, HWriteM,
//   HAddrM, HWDataM         : data side request, direction, address, write data
//   HReady                  : memory completed the current beat
//   HRequest, HWrite,
//   HAddr, HWData           : muxed bus presented to memory
//   BusReadyF, BusReadyM    : HReady routed to the granted side only
//   GrantF, GrantM          : side owning the bus this cycle (never both)
import mem_bus_arbiter_pkg::*;

module mem_bus_arbiter #(
  parameter int blocksize = 4,
  parameter int MaxBursts = 2,
  parameter int addrbits  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                HRequestF,
  input  logic [addrbits-1:0] HAddrF,
  input  logic                HRequestM,
  input  logic                HWriteM,
  input  logic [addrbits-1:0] HAddrM,
  input  logic [31:0]         HWDataM,
  input  logic                HReady,
  output logic                HRequest,
  output logic                HWrite,
  output logic [addrbits-1:0] HAddr,
  output logic [31:0]         HWData,
  output logic                BusReadyF,
  output logic                BusReadyM,
  output logic                GrantF,
  output logic                GrantM
);

  owner_state_e state, state_n;
  logic         LastOwner, LastOwner_n;
  logic         side, grant_any, clear, own_req, other_req;
  logic         LastBeat, BurstLimit, beat;
  logic [addrbits-1:0] addr_sel;
  logic [31:0]         wdata_sel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      LastOwner <= SIDE_F;
    end else begin
      state     <= state_n;
      LastOwner <= LastOwner_n;
    end
  end

  always_comb begin
    state_n     = state;
    LastOwner_n = LastOwner;
    side        = SIDE_F;
    grant_any   = 1'b0;
    clear       = 1'b0;
    own_req     = 1'b0;
    other_req   = 1'b0;
    case (state)
      IDLE: begin
        // Zero-latency park: the winner is granted in this same cycle.
        if (HRequestF || HRequestM) begin
          grant_any = 1'b1;
          if (HRequestF && HRequestM) side = ~LastOwner;
          else                        side = HRequestM ? SIDE_M : SIDE_F;
          state_n = (side == SIDE_M) ? OWN_M : OWN_F;
        end
      end
      OWN_F, OWN_M: begin
        grant_any = 1'b1;
        side      = (state == OWN_M) ? SIDE_M : SIDE_F;
        own_req   = (side == SIDE_M) ? HRequestM : HRequestF;
        other_req = (side == SIDE_M) ? HRequestF : HRequestM;
        if (!own_req) begin
          state_n     = IDLE;
          clear       = 1'b1;
          LastOwner_n = side;
        end else if (LastBeat && other_req && BurstLimit) begin
          state_n     = (side == SIDE_M) ? OWN_F : OWN_M;
          clear       = 1'b1;
          LastOwner_n = side;
        end
      end
      default: state_n = IDLE;
    endcase
    // Requests may be high while reset is held; nothing reaches the bus then.
    if (!reset) grant_any = 1'b0;
  end

  assign beat = HReady && grant_any;

  burst_beat_counter #(
    .blocksize (blocksize),
    .MaxBursts (MaxBursts)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .HReady     (beat),
    .clear      (clear),
    .LastBeat   (LastBeat),
    .BurstLimit (BurstLimit)
  );

  mux2 #(.WIDTH(addrbits)) u_addr_mux (
    .d0 (HAddrF),
    .d1 (HAddrM),
    .s  (side),
    .y  (addr_sel)
  );

  mux2 #(.WIDTH(32)) u_wdata_mux (
    .d0 ('0),
    .d1 (HWDataM),
    .s  (side),
    .y  (wdata_sel)
  );

  assign GrantF    = grant_any && (side == SIDE_F);
  assign GrantM    = grant_any && (side == SIDE_M);
  assign HRequest  = grant_any && ((side == SIDE_M) ? HRequestM : HRequestF);
  assign HWrite    = GrantM && HWriteM;
  assign HAddr     = grant_any ? addr_sel : '0;
  assign HWData    = grant_any ? wdata_sel : '0;
  assign BusReadyF = GrantF && HReady;
  assign BusReadyM = GrantM && HReady;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int BS = 4;
  localparam int MB = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        HRequestF, HRequestM, HWriteM, HReady;
  logic [31:0] HAddrF, HAddrM, HWDataM;
  logic        HRequest, HWrite, BusReadyF, BusReadyM, GrantF, GrantM;
  logic [31:0] HAddr, HWData;

  mem_bus_arbiter #(
    .blocksize (BS),
    .MaxBursts (MB),
    .addrbits  (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .HRequestF (HRequestF),
    .HAddrF    (HAddrF),
    .HRequestM (HRequestM),
    .HWriteM   (HWriteM),
    .HAddrM    (HAddrM),
    .HWDataM   (HWDataM),
    .HReady    (HReady),
    .HRequest  (HRequest),
    .HWrite    (HWrite),
    .HAddr     (HAddr),
    .HWData    (HWData),
    .BusReadyF (BusReadyF),
    .BusReadyM (BusReadyM),
    .GrantF    (GrantF),
    .GrantM    (GrantM)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: owner 0 = none, 1 = F, 2 = M; last uses 1 = F, 2 = M.
  int m_owner = 0, m_beats = 0, m_bursts = 0, m_last = 1;

  // DUT outputs captured at the last sample point, for literal checks.
  logic        s_gf, s_gm, s_req, s_wr, s_brf, s_brm;
  logic [31:0] s_addr, s_wd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at posedge+1, compare at negedge, advance the model.
  task automatic cycle(input logic rst, input logic rf, input logic [31:0] af,
                       input logic rm, input logic wm, input logic [31:0] am,
                       input logic [31:0] dm, input logic hr);
    int cur, own_req, oth_req;
    reset = rst; HRequestF = rf; HAddrF = af; HRequestM = rm;
    HWriteM = wm; HAddrM = am; HWDataM = dm; HReady = hr;
    #4;
    cur = 0;
    if (rst) begin
      if (m_owner != 0)    cur = m_owner;
      else if (rf && rm)   cur = (m_last == 1) ? 2 : 1;
      else if (rm)         cur = 2;
      else if (rf)         cur = 1;
    end
    s_gf = GrantF; s_gm = GrantM; s_req = HRequest; s_wr = HWrite;
    s_brf = BusReadyF; s_brm = BusReadyM; s_addr = HAddr; s_wd = HWData;
    chk("GrantF",    64'(GrantF),    64'(cur == 1));
    chk("GrantM",    64'(GrantM),    64'(cur == 2));
    chk("HRequest",  64'(HRequest),  64'((cur == 1 && rf) || (cur == 2 && rm)));
    chk("HWrite",    64'(HWrite),    64'(cur == 2 && wm));
    chk("HAddr",     64'(HAddr),     64'((cur == 1) ? af : (cur == 2) ? am : 32'h0));
    chk("HWData",    64'(HWData),    64'((cur == 2) ? dm : 32'h0));
    chk("BusReadyF", 64'(BusReadyF), 64'(cur == 1 && hr));
    chk("BusReadyM", 64'(BusReadyM), 64'(cur == 2 && hr));
    if (!rst) begin
      m_owner = 0; m_beats = 0; m_bursts = 0; m_last = 1;
    end else if (cur != 0) begin
      own_req = (cur == 1) ? int'(rf) : int'(rm);
      oth_req = (cur == 1) ? int'(rm) : int'(rf);
      if (own_req == 0) begin
        m_owner = 0; m_beats = 0; m_bursts = 0; m_last = cur;
      end else begin
        m_owner = cur;
        if (hr) begin
          m_beats++;
          if (m_beats == BS) begin
            m_beats = 0;
            m_bursts++;
            if (oth_req != 0 && m_bursts >= MB) begin
              m_owner = 3 - cur; m_bursts = 0; m_last = cur;
            end
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
  endtask

  initial begin : stim
    int pulses;
    logic [6:0] stall;
    logic rf, rm, wm, rst;
    int rst_hold;
    reset = 1'b0; HRequestF = 1'b0; HRequestM = 1'b0; HWriteM = 1'b0;
    HAddrF = '0; HAddrM = '0; HWDataM = '0; HReady = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with both sides requesting: bus fully quiet.
    do_reset();
    chk("rst_grant", {62'd0, s_gf, s_gm}, 64'd0);
    chk("rst_bus", {s_req, s_wr, s_brf, s_brm, s_addr, s_wd}, 64'd0);

    // M-only read of one line, then drop.
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1);
      if (i == 0) chk("mread_grant0", 64'(s_gm), 64'd1);
      if (i == 0) chk("mread_addr", 64'(s_addr), 64'h100);
      pulses += int'(s_brm);
    end
    chk("mread_pulses", 64'(pulses), 64'd4);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h100, 32'h0, 1'b1);
    chk("mread_idle", {62'd0, s_gf, s_gm}, 64'd0);

    // Tie out of reset goes to M; after M drops, F wins; next tie is M again.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 32'hF00, 1'b1, 1'b0, 32'h200, 32'h0, 1'b1);
      if (i == 0) chk("tie_first_M", 64'(s_gm), 64'd1);
    end
    cycle(1'b1, 1'b1, 32'hF00, 1'b0, 1'b0, 32'h200, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 32'hF00, 1'b0, 1'b0, 32'h200, 32'h0, 1'b1);
    chk("tie_then_F", 64'(s_gf), 64'd1);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b1, 32'hF04, 1'b0, 1'b0, 32'h200, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'hF04, 1'b0, 1'b0, 32'h200, 32'h0, 1'b0);

    // Writeback (beats 0-3) then refill (beats 4-7) stays atomic against F.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1, 32'hF08, 1'b1, (i < 4), 32'h300 + 32'(i), 32'hA000 + 32'(i), 1'b1);
      if (i == 0) chk("tie2_M", 64'(s_gm), 64'd1);
      if (i == 2) chk("wb_hwrite", 64'(s_wr), 64'd1);
      if (i == 5) chk("refill_hwrite", 64'(s_wr), 64'd0);
      if (i == 7) chk("wb_still_M", 64'(s_gm), 64'd1);
    end
    cycle(1'b1, 1'b1, 32'hF08, 1'b1, 1'b0, 32'h308, 32'h0, 1'b1);
    chk("wb_handover_F", 64'(s_gf), 64'd1);

    // Starvation guard: M wants 3 bursts, F waiting gets the bus after 8 beats.
    do_reset();
    for (int i = 0; i < 8; i++)
      cycle(1'b1, (i > 0), 32'h400, 1'b1, 1'b0, 32'h500, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 32'h400, 1'b1, 1'b0, 32'h500, 32'h0, 1'b1);
      if (i == 0) chk("starve_F", 64'(s_gf), 64'd1);
    end
    cycle(1'b1, 1'b0, 32'h400, 1'b1, 1'b0, 32'h500, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h400, 1'b1, 1'b0, 32'h500, 32'h0, 1'b1);
    chk("starve_M_resumes", 64'(s_gm), 64'd1);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b0, 32'h400, 1'b1, 1'b0, 32'h504, 32'h0, 1'b1);

    // Stalled memory: 1,0,0,1,1,0,1 completes exactly one burst.
    do_reset();
    stall = 7'b1011001;
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h600, 32'h0, stall[i]);
      pulses += int'(s_brm);
    end
    chk("stall_pulses", 64'(pulses), 64'd4);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h600, 32'h0, 1'b0);

    // Reset in the middle of an F burst.
    do_reset();
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b1, 32'h700, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 32'h700, 1'b1, 1'b1, 32'h800, 32'h5, 1'b1);
    chk("midrst_quiet", {s_gf, s_gm, s_req, s_wr, s_brf, s_brm, s_addr[15:0]}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1, 32'h700, 1'b1, 1'b0, 32'h800, 32'h0, 1'b1);
      if (i == 0) chk("midrst_M", 64'(s_gm), 64'd1);
    end

    // Randomized traffic against the model.
    rf = 1'b0; rm = 1'b0; wm = 1'b0; rst_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (rf) rf = ($urandom_range(0, 11) != 0); else rf = ($urandom_range(0, 3) == 0);
      if (rm) rm = ($urandom_range(0, 11) != 0); else rm = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) wm = ~wm;
      if (rst_hold > 0) rst_hold--;
      else if ($urandom_range(0, 299) == 0) rst_hold = $urandom_range(1, 2);
      rst = (rst_hold == 0);
      cycle(rst, rf, $urandom, rm, wm, $urandom, $urandom, ($urandom_range(0, 9) < 7));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
